// File: rtl/conv_mem_host_if.sv
// rtl/conv_mem_host_if.sv - host stream, engine access and dump signals of conv_mem_host
// master = host/engine side, slave = conv_mem_host.
interface conv_mem_host_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 13
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] idata;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              csel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
           crd, caddr_rd, csel, out_ready,
    input  in_ready, ready, idata, cdata_rd, out_valid, out_data, done, err
  );

  modport slave (
    input  in_valid, in_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
           crd, caddr_rd, csel, out_ready,
    output in_ready, ready, idata, cdata_rd, out_valid, out_data, done, err
  );
endinterface

// File: rtl/conv_mem_host.sv
// rtl/conv_mem_host.sv - image/layer memory responder for the 3x3 convolution engine
// Loads an image from the host, serves engine reads/writes, then dumps layer 1.
module conv_mem_host #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 13,
  parameter int IMG_PIX = 4096,
  parameter int L1_PIX  = 1024
) (
  input  logic           clk,
  input  logic           reset,
  conv_mem_host_if.slave bus
);
  localparam int L1_W = $clog2(L1_PIX);

  typedef enum logic [2:0] {LOAD, START, RUN, DUMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [L1_W-1:0]   dump_cnt_q, dump_cnt_d;
  logic              seen_busy_q, seen_busy_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] img [IMG_PIX];
  logic [DATA_W-1:0] l0  [IMG_PIX];
  logic [DATA_W-1:0] l1  [L1_PIX];

  logic wr_win, wr_l1_oob, rd_l1_oob, wr_ok, load_fire;

  always_comb begin
    wr_win    = (state_q == START) || (state_q == RUN);
    wr_l1_oob = bus.csel && (bus.caddr_wr >= ADDR_W'(L1_PIX));
    rd_l1_oob = bus.csel && (bus.caddr_rd >= ADDR_W'(L1_PIX));
    // A write colliding with a read is refused so the read path never races it.
    wr_ok     = bus.cwr && wr_win && !bus.crd && !wr_l1_oob;
    load_fire = (state_q == LOAD) && bus.in_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      ld_cnt_q    <= '0;
      dump_cnt_q  <= '0;
      seen_busy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      dump_cnt_q  <= dump_cnt_d;
      seen_busy_q <= seen_busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    dump_cnt_d    = dump_cnt_q;
    seen_busy_d   = seen_busy_q;
    err_d         = err_q
                  | (bus.cwr && (!wr_win || bus.crd || wr_l1_oob))
                  | (bus.crd && rd_l1_oob);
    bus.in_ready  = 1'b0;
    bus.ready     = 1'b0;
    bus.out_valid = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == ADDR_W'(IMG_PIX - 1)) state_d = START;
        end
      end
      START: begin
        bus.ready = 1'b1;
        if (bus.busy) begin
          seen_busy_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (!bus.busy && seen_busy_q) state_d = DUMP;
      end
      DUMP: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          dump_cnt_d = dump_cnt_q + 1'b1;
          if (dump_cnt_q == L1_W'(L1_PIX - 1)) state_d = DONE;
        end
      end
      DONE: bus.done = 1'b1;
      default: state_d = LOAD;
    endcase
  end

  // Memories keep their contents across reset.
  always_ff @(posedge clk) begin
    if (load_fire) img[ld_cnt_q] <= bus.in_data;
    if (wr_ok) begin
      if (bus.csel) l1[bus.caddr_wr[L1_W-1:0]] <= bus.cdata_wr;
      else          l0[bus.caddr_wr]           <= bus.cdata_wr;
    end
  end

  assign bus.idata    = img[bus.iaddr];
  assign bus.out_data = l1[dump_cnt_q];
  assign bus.err      = err_q;

  always_comb begin
    bus.cdata_rd = '0;
    if (bus.crd && !rd_l1_oob)
      bus.cdata_rd = bus.csel ? l1[bus.caddr_rd[L1_W-1:0]] : l0[bus.caddr_rd];
  end
endmodule

// File: tb/tb_conv_mem_host.sv
// tb/tb_conv_mem_host.sv - directed bench for conv_mem_host
// Engine accesses come from a vector table; load, dump and reset are hand sequences.
module tb_conv_mem_host;
  logic clk = 1'b0;
  logic reset;

  conv_mem_host_if #(.ADDR_W(12), .DATA_W(13)) bus ();

  conv_mem_host #(.ADDR_W(12), .DATA_W(13), .IMG_PIX(4096), .L1_PIX(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cwr;
    logic        crd;
    logic        csel;
    logic [11:0] aw;
    logic [12:0] dw;
    logic [11:0] ar;
    logic [12:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];
  int   nvec = 0;
  int   nbad = 0;

  function automatic vec_t mk(logic cwr, logic crd, logic csel, int aw, int dw, int ar,
                              int er, logic ee);
    vec_t v;
    v.cwr = cwr; v.crd = crd; v.csel = csel;
    v.aw = 12'(aw); v.dw = 13'(dw); v.ar = 12'(ar);
    v.exp_rd = 13'(er); v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_a, bad_b, bad_c;
    logic [11:0] ia [4];
    // Image loaded as value = address, so idata must echo the address.
    ia[0] = 12'h000; ia[1] = 12'h001; ia[2] = 12'h7FF; ia[3] = 12'hFFF;

    vecs[0]  = mk(1, 0, 0,    5, 'h123,    0, 'h000, 0);
    vecs[1]  = mk(0, 1, 0,    0, 'h000,    5, 'h123, 0);
    vecs[2]  = mk(1, 0, 1, 1023, 'h050,    0, 'h000, 0);
    vecs[3]  = mk(1, 0, 1,    0, 'h0AA,    0, 'h000, 0);
    vecs[4]  = mk(1, 0, 0, 1023, 'h1AB,    0, 'h000, 0);
    vecs[5]  = mk(0, 1, 1,    0, 'h000, 1023, 'h050, 0);
    vecs[6]  = mk(0, 1, 1,    0, 'h000,    0, 'h0AA, 0);
    vecs[7]  = mk(0, 1, 0,    0, 'h000, 1023, 'h1AB, 0);
    vecs[8]  = mk(0, 0, 0,    0, 'h000,    5, 'h000, 0);
    vecs[9]  = mk(1, 0, 1, 1024, 'h1FFF,   0, 'h000, 1);
    vecs[10] = mk(0, 1, 1,    0, 'h000,    0, 'h0AA, 1);
    vecs[11] = mk(1, 1, 0,    5, 'h777,    5, 'h123, 1);
    vecs[12] = mk(0, 1, 0,    0, 'h000,    5, 'h123, 1);
    vecs[13] = mk(0, 1, 1,    0, 'h000, 1024, 'h000, 1);

    reset = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.busy = 0; bus.iaddr = '0;
    bus.cwr = 0; bus.caddr_wr = '0; bus.cdata_wr = '0; bus.crd = 0;
    bus.caddr_rd = '0; bus.csel = 0; bus.out_ready = 0;
    step(); step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ready", bus.ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    reset = 1'b0;

    // Continuous load.
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 4096; i++) begin
      bus.in_valid = 1; bus.in_data = 13'(i);
      #3;
      if (bus.in_ready !== 1'b1) bad_a++;
      if (bus.ready !== 1'b0) bad_b++;
      step();
    end
    bus.in_valid = 0;
    #3;
    chk("load_in_ready_held", bad_a, 0);
    chk("load_ready_low", bad_b, 0);
    chk("start_ready", bus.ready, 1);
    chk("start_in_ready", bus.in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      bus.iaddr = ia[k];
      #1;
      chk($sformatf("idata[%0h]", ia[k]), bus.idata, {19'd0, 1'b0, ia[k]});
    end

    step(); step();
    bus.busy = 1;
    #3;
    chk("ready_before_busy_edge", bus.ready, 1);
    step();
    #3;
    chk("ready_after_busy", bus.ready, 0);
    step();

    for (int v = 0; v < 14; v++) begin
      bus.cwr = vecs[v].cwr; bus.crd = vecs[v].crd; bus.csel = vecs[v].csel;
      bus.caddr_wr = vecs[v].aw; bus.cdata_wr = vecs[v].dw; bus.caddr_rd = vecs[v].ar;
      #3;
      chk($sformatf("vec%0d_cdata_rd", v), bus.cdata_rd, vecs[v].exp_rd);
      step();
      chk($sformatf("vec%0d_err", v), bus.err, vecs[v].exp_err);
    end
    bus.cwr = 0; bus.crd = 0; bus.csel = 0;

    // Dump with an initial 3-cycle stall.
    bus.busy = 0;
    step();
    #3;
    chk("dump_valid", bus.out_valid, 1);
    chk("dump_word0", bus.out_data, 13'h0AA);
    step();
    bad_a = 0;
    for (int s = 0; s < 3; s++) begin
      #3;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 13'h0AA) bad_a++;
      step();
    end
    chk("dump_stall_stable", bad_a, 0);
    bus.out_ready = 1;
    bad_b = 0;
    for (int k = 0; k < 1024; k++) begin
      #3;
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b1) bad_b++;
      if (k == 1023) chk("dump_word1023", bus.out_data, 13'h050);
      step();
    end
    bus.out_ready = 0;
    #3;
    chk("dump_valid_during", bad_b, 0);
    chk("done_set", bus.done, 1);
    chk("done_out_valid", bus.out_valid, 0);

    // Second pass: backpressured load, then reset in the middle of the dump.
    reset = 1'b1;
    step();
    reset = 1'b0;
    bad_c = 0;
    for (int i = 0; i < 8192; i++) begin
      bus.in_valid = (i % 2 == 0); bus.in_data = 13'(i / 2);
      #3;
      if (bus.ready !== (i == 8191)) bad_c++;
      step();
    end
    bus.in_valid = 0;
    #3;
    chk("bp_ready_timing", bad_c, 0);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.iaddr = 12'hFFF;
    #1;
    chk("bp_idata_fff", bus.idata, 13'h0FFF);
    bus.iaddr = 12'h800;
    #1;
    chk("bp_idata_800", bus.idata, 13'h0800);
    step();
    bus.busy = 1;
    step();
    bus.cwr = 1; bus.csel = 1; bus.caddr_wr = 12'd1024; bus.cdata_wr = 13'h0001;
    step();
    bus.cwr = 0; bus.csel = 0;
    chk("bp_err_set", bus.err, 1);
    bus.busy = 0;
    step();
    bus.out_ready = 1;
    for (int k = 0; k < 500; k++) step();
    chk("mid_dump_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_err", bus.err, 0);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    bus.out_ready = 0;
    step();
    reset = 1'b0;

    // Writes are refused in LOAD; old layer-0 contents survive reset.
    bus.cwr = 1; bus.csel = 0; bus.caddr_wr = 12'd5; bus.cdata_wr = 13'h03FF;
    step();
    bus.cwr = 0;
    chk("load_write_err", bus.err, 1);
    bus.crd = 1; bus.caddr_rd = 12'd5;
    #1;
    chk("load_write_blocked", bus.cdata_rd, 13'h0123);
    bus.crd = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
